// File: rtl/rca_profile_scanner.sv
// rca_profile_scanner: locks the branch profiler, scans every entry and reports
// the hottest valid entry whose taken count reaches THRESHOLD.
module rca_profile_scanner #(
  parameter int NUM_ENTRIES = 8,
  parameter int COUNT_W = 4,
  parameter int XLEN = 32,
  parameter int THRESHOLD = 12,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               lock_o,
  output logic               rd_en,
  output logic [IW-1:0]      rd_idx,
  input  logic [XLEN-1:0]    rd_addr,
  input  logic               rd_entry_valid,
  input  logic [COUNT_W-1:0] rd_count,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic [IW-1:0]      res_idx,
  output logic [XLEN-1:0]    res_addr,
  output logic [COUNT_W-1:0] res_count,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, LOCK, SCAN, RESULT} state_t;
  state_t state, state_nx;
  logic [IW:0] cnt;
  logic pending, last, eval, take;
  assign last = state == SCAN && cnt == (IW+1)'(NUM_ENTRIES);
  // read data lags rd_en by one cycle, so count c evaluates entry c-1
  assign eval = state == SCAN && cnt != '0;
  assign take = eval && rd_entry_valid && rd_count >= COUNT_W'(THRESHOLD) &&
                (!res_found || rd_count > res_count);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state != IDLE && abort) ? IDLE :
               state == IDLE ? ((start || pending) ? LOCK : IDLE) :
               state == LOCK ? SCAN :
               state == SCAN ? (last ? RESULT : SCAN) :
               (res_ready ? IDLE : RESULT);
  always_comb begin
    lock_o = state != IDLE;
    busy = state != IDLE;
    rd_en = state == SCAN && cnt < (IW+1)'(NUM_ENTRIES);
    rd_idx = rd_en ? cnt[IW-1:0] : '0;
    res_valid = state == RESULT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      pending <= 1'b0;
      res_found <= 1'b0;
      res_idx <= '0;
      res_addr <= '0;
      res_count <= '0;
    end else begin
      cnt <= (state == SCAN && state_nx == SCAN) ? cnt + 1'b1 : '0;
      pending <= state != IDLE && !abort && (pending || start);
      if (state == IDLE && (start || pending)) begin
        res_found <= 1'b0;
        res_idx <= '0;
        res_addr <= '0;
        res_count <= '0;
      end else if (take) begin
        res_found <= 1'b1;
        res_idx <= IW'(cnt - 1'b1);
        res_addr <= rd_addr;
        res_count <= rd_count;
      end
    end
endmodule

// File: tb/tb_rca_profile_scanner.sv
// tb_rca_profile_scanner: directed checks of scan results, latency, backpressure,
// pending start, abort and asynchronous reset.
module tb_rca_profile_scanner;
  localparam int N = 8, CW = 4, XL = 32, IW = 3;
  logic clk = 0, rst = 0, start = 0, abort = 0, res_ready = 0;
  logic rd_entry_valid = 0;
  logic [XL-1:0] rd_addr = '0;
  logic [CW-1:0] rd_count = '0;
  logic lock_o, rd_en, res_valid, res_found, busy;
  logic [IW-1:0] rd_idx, res_idx;
  logic [XL-1:0] res_addr;
  logic [CW-1:0] res_count;
  logic [XL-1:0] m_addr[N];
  logic [CW-1:0] m_cnt[N];
  logic m_val[N];
  int checks = 0, errors = 0;

  rca_profile_scanner #(.NUM_ENTRIES(N), .COUNT_W(CW), .XLEN(XL), .THRESHOLD(12)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lock_o(lock_o), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_addr(rd_addr), .rd_entry_valid(rd_entry_valid), .rd_count(rd_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found), .res_idx(res_idx),
    .res_addr(res_addr), .res_count(res_count), .busy(busy));

  always #5 clk = ~clk;

  // profiler model: one-cycle read latency
  always @(posedge clk)
    if (rd_en) begin
      rd_addr <= m_addr[rd_idx];
      rd_count <= m_cnt[rd_idx];
      rd_entry_valid <= m_val[rd_idx];
    end

  // cs holds entry i's count in nibble i; addresses are 0x4000_0000 + 16*i
  task automatic load(input logic [31:0] cs, input logic [7:0] vs);
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = cs[4*i +: 4];
      m_val[i] = vs[i];
      m_addr[i] = 32'h4000_0000 + 32'(i * 16);
    end
  endtask

  // start sampled at edge k; returns at the negedge of cycle k+1
  task automatic kick();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  // n counts negedges since edge k at which res_valid was first seen (40 = timeout)
  task automatic wait_res(inout int n);
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic accept();
    res_ready = 1;
    @(negedge clk); res_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({lock_o, rd_en, rd_idx, res_valid, res_found, res_idx, res_addr, res_count, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: lock=%b rd_en=%b valid=%b busy=%b found=%b idx=%0d addr=%h cnt=%0d required all 0",
        lock_o, rd_en, res_valid, busy, res_found, res_idx, res_addr, res_count);
    end
    rst = 1;
  endtask

  task automatic test_basic();
    int n;
    load(32'h9000_FFD3, 8'hFF);
    kick();
    checks++;
    if (lock_o !== 1 || rd_en !== 0) begin errors++; $display("FAIL basic_lock_k1: lock=%b rd_en=%b required 1 0", lock_o, rd_en); end
    @(negedge clk);
    checks++;
    if (rd_en !== 1 || rd_idx !== 0) begin errors++; $display("FAIL basic_rd_k2: rd_en=%b rd_idx=%0d required 1 0", rd_en, rd_idx); end
    n = 2;
    wait_res(n);
    checks++;
    if (n !== 11) begin errors++; $display("FAIL basic_latency: res_valid at cycle k+%0d required k+11", n); end
    checks++;
    if (res_found !== 1 || res_idx !== 2 || res_count !== 15 || res_addr !== 32'h4000_0020) begin
      errors++; $display("FAIL basic_result: found=%b idx=%0d cnt=%0d addr=%h required 1 2 15 40000020", res_found, res_idx, res_count, res_addr);
    end
    accept();
    checks++;
    if (busy !== 0 || lock_o !== 0 || res_valid !== 0) begin errors++; $display("FAIL basic_idle: busy=%b lock=%b valid=%b required 0 0 0", busy, lock_o, res_valid); end
  endtask

  task automatic test_invalid_entry();
    int n;
    load(32'h1_7F2_50B3, 8'b1101_1111);
    kick();
    n = 1;
    wait_res(n);
    checks++;
    if (n !== 11 || res_found !== 0 || res_idx !== 0 || res_addr !== 0 || res_count !== 0) begin
      errors++; $display("FAIL invalid_entry: cyc=%0d found=%b idx=%0d addr=%h cnt=%0d required 11 0 0 0 0", n, res_found, res_idx, res_addr, res_count);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int n, bad;
    load(32'h9000_FFD3, 8'hFF);
    kick();
    n = 1;
    wait_res(n);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1 || lock_o !== 1 || res_found !== 1 || res_idx !== 2 || res_count !== 15 || res_addr !== 32'h4000_0020) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL backpressure_stable: %0d unstable cycles required 0", bad); end
    accept();
    checks++;
    if (lock_o !== 0 || busy !== 0) begin errors++; $display("FAIL backpressure_release: lock=%b busy=%b required 0 0", lock_o, busy); end
  endtask

  task automatic test_back_to_back();
    int n, results;
    load(32'h9000_FFD3, 8'hFF);
    kick();
    repeat (2) @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    n = 6;
    wait_res(n);
    results = res_valid ? 1 : 0;
    accept();
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL b2b_idle_gap: busy=%b required 0", busy); end
    @(negedge clk);
    checks++;
    if (lock_o !== 1 || res_valid !== 0) begin errors++; $display("FAIL b2b_relock: lock=%b valid=%b required 1 0", lock_o, res_valid); end
    n = 1;
    wait_res(n);
    checks++;
    if (n !== 11 || res_idx !== 2 || res_count !== 15) begin errors++; $display("FAIL b2b_second: cyc=%0d idx=%0d cnt=%0d required 11 2 15", n, res_idx, res_count); end
    if (res_valid) results++;
    accept();
    for (int i = 0; i < 30; i++) begin
      if (res_valid) begin results++; accept(); end
      else @(negedge clk);
    end
    checks++;
    if (results !== 2 || busy !== 0) begin errors++; $display("FAIL b2b_count: results=%0d busy=%b required 2 0", results, busy); end
  endtask

  task automatic test_abort();
    int n, seen;
    load(32'h9000_FFD3, 8'hFF);
    kick();
    n = 0;
    while (!(rd_en && rd_idx == 4) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL abort_reach_c4: reached at +%0d required +5", n); end
    abort = 1; @(negedge clk); abort = 0;
    checks++;
    if (lock_o !== 0 || busy !== 0 || res_valid !== 0 || rd_en !== 0) begin
      errors++; $display("FAIL abort_idle: lock=%b busy=%b valid=%b rd_en=%b required 0 0 0 0", lock_o, busy, res_valid, rd_en);
    end
    seen = 0;
    repeat (15) begin @(negedge clk); if (res_valid || busy) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_quiet: %0d active cycles required 0", seen); end
    load(32'h0000_D000, 8'hFF);
    kick();
    @(negedge clk);
    checks++;
    if (rd_en !== 1 || rd_idx !== 0) begin errors++; $display("FAIL abort_rescan: rd_en=%b rd_idx=%0d required 1 0", rd_en, rd_idx); end
    n = 2;
    wait_res(n);
    checks++;
    if (n !== 11 || res_found !== 1 || res_idx !== 3 || res_count !== 13 || res_addr !== 32'h4000_0030) begin
      errors++; $display("FAIL abort_result: cyc=%0d found=%b idx=%0d cnt=%0d addr=%h required 11 1 3 13 40000030", n, res_found, res_idx, res_count, res_addr);
    end
    accept();
  endtask

  task automatic test_async_reset();
    int seen;
    load(32'h9000_FFD3, 8'hFF);
    kick();
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if (lock_o !== 0 || rd_en !== 0 || busy !== 0 || res_valid !== 0) begin
      errors++; $display("FAIL async_reset: lock=%b rd_en=%b busy=%b valid=%b required 0 0 0 0", lock_o, rd_en, busy, res_valid);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (res_valid || busy) seen++; end
    rst = 1;
    repeat (15) begin @(negedge clk); if (res_valid || busy) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_no_result: %0d active cycles required 0", seen); end
    rst = 0;
    @(negedge clk);
    rst = 1; start = 1;
    @(negedge clk); start = 0;
    checks++;
    if (lock_o !== 1) begin errors++; $display("FAIL first_start_after_reset: lock=%b required 1", lock_o); end
    seen = 1;
    wait_res(seen);
    accept();
  endtask

  task automatic test_tie_same_edge();
    int n;
    load(32'h0C00_C0CB, 8'b1011_1111);
    kick();
    n = 1;
    wait_res(n);
    checks++;
    if (n !== 11 || res_found !== 1 || res_idx !== 1 || res_count !== 12 || res_addr !== 32'h4000_0010) begin
      errors++; $display("FAIL tie_threshold: cyc=%0d found=%b idx=%0d cnt=%0d addr=%h required 11 1 1 12 40000010", n, res_found, res_idx, res_count, res_addr);
    end
    res_ready = 1; start = 1;
    @(negedge clk); res_ready = 0; start = 0;
    checks++;
    if (busy !== 0 || res_valid !== 0) begin errors++; $display("FAIL same_edge_idle: busy=%b valid=%b required 0 0", busy, res_valid); end
    @(negedge clk);
    checks++;
    if (lock_o !== 1) begin errors++; $display("FAIL same_edge_relock: lock=%b required 1", lock_o); end
    n = 1;
    wait_res(n);
    checks++;
    if (n !== 11 || res_idx !== 1 || res_count !== 12) begin errors++; $display("FAIL same_edge_result: cyc=%0d idx=%0d cnt=%0d required 11 1 12", n, res_idx, res_count); end
    accept();
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL same_edge_done: busy=%b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid_entry();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_tie_same_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
